execute_stage_md: RTL and testbench

EXECUTE_STAGE_MD -- requirements
Module: execute_stage_md

---
 rtl/exec_pkg.sv | 35 +++
 rtl/execute_stage_md_if.sv | 49 ++++
 rtl/md_unit.sv | 118 +++++++++++
 rtl/execute_stage_md.sv | 123 ++++++++++++
 tb/tb_execute_stage_md.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared ALU/MD opcodes, forward selects and MD FSM state for the execute stage
package exec_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;

    localparam logic [1:0] FWD_REG     = 2'd0;
    localparam logic [1:0] FWD_RESULTW = 2'd1;
    localparam logic [1:0] FWD_ALUOUTM = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/execute_stage_md_if.sv
// rtl/execute_stage_md_if.sv - decode/forwarding inputs and execute-stage outputs bundled as one bus
interface execute_stage_md_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    localparam int SH_W = $clog2(DATA_W);

    logic              FlushE;
    logic              StallE;
    logic [2:0]        CtrlD;
    logic [3:0]        ALUControlD;
    logic              ALUSrcD;
    logic              RegDstD;
    logic [2:0]        MDOpD;
    logic [DATA_W-1:0] RD1D;
    logic [DATA_W-1:0] RD2D;
    logic [DATA_W-1:0] SignImmD;
    logic [REG_AW-1:0] RsD;
    logic [REG_AW-1:0] RtD;
    logic [REG_AW-1:0] RdD;
    logic [SH_W-1:0]   ShamtD;
    logic [DATA_W-1:0] ResultW;
    logic [DATA_W-1:0] ALUOutM;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;

    logic [2:0]        CtrlE;
    logic [REG_AW-1:0] RsE;
    logic [REG_AW-1:0] RtE;
    logic [REG_AW-1:0] WriteRegE;
    logic [DATA_W-1:0] WriteDataE;
    logic [DATA_W-1:0] ALUOutE;
    logic              MDBusyE;

    modport master (
        output FlushE, StallE, CtrlD, ALUControlD, ALUSrcD, RegDstD, MDOpD,
               RD1D, RD2D, SignImmD, RsD, RtD, RdD, ShamtD, ResultW, ALUOutM,
               ForwardAE, ForwardBE,
        input  CtrlE, RsE, RtE, WriteRegE, WriteDataE, ALUOutE, MDBusyE
    );

    modport slave (
        input  FlushE, StallE, CtrlD, ALUControlD, ALUSrcD, RegDstD, MDOpD,
               RD1D, RD2D, SignImmD, RsD, RtD, RdD, ShamtD, ResultW, ALUOutM,
               ForwardAE, ForwardBE,
        output CtrlE, RsE, RtE, WriteRegE, WriteDataE, ALUOutE, MDBusyE
    );

endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative shift-add multiplier / restoring divider producing HI and LO
module md_unit
    import exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        md_op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);

    md_state_e           state_q;
    logic [SH_W-1:0]     cnt_q;
    logic [2*DATA_W-1:0] work_q;
    logic [DATA_W-1:0]   operand_q;
    logic [DATA_W-1:0]   dividend_q;
    logic                is_div_q;
    logic                div_zero_q;
    logic                neg_res_q;
    logic                neg_rem_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic                signed_op;
    logic                neg_a;
    logic                neg_b;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] mul_next_d;
    logic [2*DATA_W-1:0] div_next_d;

    assign signed_op = (md_op_i == MD_MULT) || (md_op_i == MD_DIV);
    assign neg_a     = signed_op & a_i[DATA_W-1];
    assign neg_b     = signed_op & b_i[DATA_W-1];
    assign mag_a     = neg_a ? -a_i : a_i;
    assign mag_b     = neg_b ? -b_i : b_i;

    // work_q is {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    assign mul_sum    = {1'b0, work_q[2*DATA_W-1:DATA_W]} + (work_q[0] ? {1'b0, operand_q} : '0);
    assign mul_next_d = {mul_sum, work_q[DATA_W-1:1]};

    assign div_shift  = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
    assign div_diff   = div_shift - {1'b0, operand_q};
    assign div_next_d = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], work_q[DATA_W-2:0], 1'b0}
                                         : {div_diff[DATA_W-1:0], work_q[DATA_W-2:0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            operand_q  <= '0;
            dividend_q <= '0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q      <= '0;
                    neg_res_q  <= neg_a ^ neg_b;
                    neg_rem_q  <= neg_a;
                    dividend_q <= a_i;
                    div_zero_q <= (b_i == '0);
                    if (md_op_i == MD_MULT || md_op_i == MD_MULTU) begin
                        state_q   <= S_MUL;
                        is_div_q  <= 1'b0;
                        work_q    <= {{DATA_W{1'b0}}, mag_b};
                        operand_q <= mag_a;
                    end else if (md_op_i == MD_DIV || md_op_i == MD_DIVU) begin
                        state_q   <= S_DIV;
                        is_div_q  <= 1'b1;
                        work_q    <= {{DATA_W{1'b0}}, mag_a};
                        operand_q <= mag_b;
                    end
                end
                S_MUL, S_DIV: begin
                    work_q <= (state_q == S_MUL) ? mul_next_d : div_next_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= neg_res_q ? -work_q : work_q;
                    end else if (div_zero_q) begin
                        lo_q <= '1;
                        hi_q <= dividend_q;
                    end else begin
                        lo_q <= neg_res_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
                        hi_q <= neg_rem_q ? -work_q[2*DATA_W-1:DATA_W] : work_q[2*DATA_W-1:DATA_W];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/execute_stage_md.sv
// rtl/execute_stage_md.sv - ID/EX register, forwarding muxes, ALU and HI/LO readout around md_unit
module execute_stage_md
    import exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic         clk,
    input logic         rst_n,
    execute_stage_md_if.slave bus
);
    localparam int SH_W = $clog2(DATA_W);

    typedef struct packed {
        logic [2:0]        ctrl;
        logic [3:0]        alu_ctrl;
        logic              alu_src;
        logic              reg_dst;
        logic [2:0]        md_op;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [SH_W-1:0]   shamt;
    } idex_t;

    idex_t             idex_q;
    idex_t             idex_d;
    logic              md_busy;
    logic [DATA_W-1:0] md_hi;
    logic [DATA_W-1:0] md_lo;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_res;

    // A busy multiply/divide freezes whatever sits in E until the unit is idle again
    always_comb begin
        idex_d = idex_q;
        if (bus.FlushE) begin
            idex_d = '0;
        end else if (!(bus.StallE || md_busy)) begin
            idex_d.ctrl     = bus.CtrlD;
            idex_d.alu_ctrl = bus.ALUControlD;
            idex_d.alu_src  = bus.ALUSrcD;
            idex_d.reg_dst  = bus.RegDstD;
            idex_d.md_op    = bus.MDOpD;
            idex_d.rd1      = bus.RD1D;
            idex_d.rd2      = bus.RD2D;
            idex_d.imm      = bus.SignImmD;
            idex_d.rs       = bus.RsD;
            idex_d.rt       = bus.RtD;
            idex_d.rd       = bus.RdD;
            idex_d.shamt    = bus.ShamtD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    always_comb begin
        case (bus.ForwardAE)
            FWD_RESULTW: src_a = bus.ResultW;
            FWD_ALUOUTM: src_a = bus.ALUOutM;
            default:     src_a = idex_q.rd1;
        endcase
        case (bus.ForwardBE)
            FWD_RESULTW: fwd_b = bus.ResultW;
            FWD_ALUOUTM: fwd_b = bus.ALUOutM;
            default:     fwd_b = idex_q.rd2;
        endcase
    end

    assign src_b = idex_q.alu_src ? idex_q.imm : fwd_b;

    always_comb begin
        alu_res = '0;
        case (idex_q.alu_ctrl)
            ALU_AND:  alu_res = src_a & src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_ADD:  alu_res = src_a + src_b;
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_SLL:  alu_res = src_b << idex_q.shamt;
            ALU_SRL:  alu_res = src_b >> idex_q.shamt;
            ALU_SUB:  alu_res = src_a - src_b;
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
            ALU_SRA:  alu_res = $signed(src_b) >>> idex_q.shamt;
            ALU_NOR:  alu_res = ~(src_a | src_b);
            default:  alu_res = '0;
        endcase
    end

    md_unit #(
        .DATA_W (DATA_W)
    ) u_md (
        .clk     (clk),
        .rst_n   (rst_n),
        .md_op_i (idex_q.md_op),
        .a_i     (src_a),
        .b_i     (fwd_b),
        .busy_o  (md_busy),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    assign bus.CtrlE      = idex_q.ctrl;
    assign bus.RsE        = idex_q.rs;
    assign bus.RtE        = idex_q.rt;
    assign bus.WriteRegE  = idex_q.reg_dst ? idex_q.rd : idex_q.rt;
    assign bus.WriteDataE = fwd_b;
    assign bus.ALUOutE    = (idex_q.md_op == MD_MFHI) ? md_hi :
                            (idex_q.md_op == MD_MFLO) ? md_lo : alu_res;
    assign bus.MDBusyE    = md_busy;

endmodule

// File: tb/tb_execute_stage_md.sv
// tb/tb_execute_stage_md.sv - directed self-checking bench for execute_stage_md (32- and 16-bit builds)
module tb_execute_stage_md;
    import exec_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    execute_stage_md_if #(.DATA_W(32), .REG_AW(5)) b32 ();
    execute_stage_md_if #(.DATA_W(16), .REG_AW(5)) b16 ();

    execute_stage_md #(.DATA_W(32), .REG_AW(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    execute_stage_md #(.DATA_W(16), .REG_AW(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle32();
        b32.FlushE = 0; b32.StallE = 0; b32.CtrlD = 0; b32.ALUControlD = 0;
        b32.ALUSrcD = 0; b32.RegDstD = 0; b32.MDOpD = 0; b32.RD1D = 0; b32.RD2D = 0;
        b32.SignImmD = 0; b32.RsD = 0; b32.RtD = 0; b32.RdD = 0; b32.ShamtD = 0;
        b32.ResultW = 0; b32.ALUOutM = 0; b32.ForwardAE = 0; b32.ForwardBE = 0;
    endtask

    task automatic idle16();
        b16.FlushE = 0; b16.StallE = 0; b16.CtrlD = 0; b16.ALUControlD = 0;
        b16.ALUSrcD = 0; b16.RegDstD = 0; b16.MDOpD = 0; b16.RD1D = 0; b16.RD2D = 0;
        b16.SignImmD = 0; b16.RsD = 0; b16.RtD = 0; b16.RdD = 0; b16.ShamtD = 0;
        b16.ResultW = 0; b16.ALUOutM = 0; b16.ForwardAE = 0; b16.ForwardBE = 0;
    endtask

    task automatic issue32(input logic [3:0] alu, input logic [2:0] md,
                           input logic [31:0] a, input logic [31:0] b);
        b32.ALUControlD = alu; b32.MDOpD = md; b32.RD1D = a; b32.RD2D = b;
    endtask

    task automatic md_run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int busy, output logic [31:0] lo, output logic [31:0] hi);
        issue32(ALU_AND, op, a, b);
        tick();
        issue32(ALU_AND, MD_MFLO, 32'd0, 32'd0);
        tick();
        busy = 0;
        while (b32.MDBusyE === 1'b1 && busy < 100) begin
            busy++;
            tick();
        end
        lo = b32.ALUOutE;
        issue32(ALU_AND, MD_MFHI, 32'd0, 32'd0);
        tick();
        hi = b32.ALUOutE;
        issue32(ALU_AND, MD_NONE, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle32();
        idle16();
        tick();
        tick();
        n_checks++;
        if (b32.CtrlE !== 3'd0) begin n_fail++; $display("FAIL reset_ctrl: got %0h expected 0", b32.CtrlE); end
        n_checks++;
        if (b32.ALUOutE !== 32'd0) begin n_fail++; $display("FAIL reset_aluout: got %0h expected 0", b32.ALUOutE); end
        n_checks++;
        if (b32.MDBusyE !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", b32.MDBusyE); end
        n_checks++;
        if (b32.WriteRegE !== 5'd0 || b32.WriteDataE !== 32'd0) begin
            n_fail++; $display("FAIL reset_wreg_wdata: got %0h/%0h expected 0/0", b32.WriteRegE, b32.WriteDataE);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_forwarding();
        logic [1:0]  fsel [3] = '{2'd0, 2'd1, 2'd2};
        logic [31:0] fexp [3] = '{32'd42, 32'd32, 32'd22};
        idle32();
        b32.RD2D = 32'd42; b32.ResultW = 32'd32; b32.ALUOutM = 32'd22;
        b32.CtrlD = 3'b111; b32.RegDstD = 1'b1; b32.RdD = 5'd9; b32.RtD = 5'd4;
        tick();
        for (int i = 0; i < 3; i++) begin
            b32.ForwardBE = fsel[i];
            #1;
            n_checks++;
            if (b32.WriteDataE !== fexp[i]) begin
                n_fail++; $display("FAIL fwd_b_sel%0d: got %0d expected %0d", fsel[i], b32.WriteDataE, fexp[i]);
            end
        end
        n_checks++;
        if (b32.CtrlE !== 3'b111 || b32.WriteRegE !== 5'd9) begin
            n_fail++; $display("FAIL load_ctrl_wreg: got %0h/%0d expected 7/9", b32.CtrlE, b32.WriteRegE);
        end
        b32.StallE = 1'b1; b32.CtrlD = 3'b010; b32.RdD = 5'd1;
        tick();
        n_checks++;
        if (b32.CtrlE !== 3'b111 || b32.WriteRegE !== 5'd9) begin
            n_fail++; $display("FAIL stall_hold: got %0h/%0d expected 7/9", b32.CtrlE, b32.WriteRegE);
        end
        b32.FlushE = 1'b1;
        tick();
        n_checks++;
        if (b32.CtrlE !== 3'd0 || b32.WriteRegE !== 5'd0) begin
            n_fail++; $display("FAIL flush_over_stall: got %0h/%0d expected 0/0", b32.CtrlE, b32.WriteRegE);
        end
        idle32();
        b32.ResultW = 32'd32;
        issue32(ALU_ADD, MD_NONE, 32'd1, 32'd2);
        b32.ForwardAE = FWD_RESULTW;
        tick();
        n_checks++;
        if (b32.ALUOutE !== 32'd34) begin n_fail++; $display("FAIL fwd_a_resultw: got %0d expected 34", b32.ALUOutE); end
        idle32();
    endtask

    task automatic test_alu();
        logic [3:0]  t_op  [10] = '{ALU_SLT, ALU_SLTU, ALU_ADD, ALU_SRA, ALU_SRL,
                                    ALU_SUB, ALU_NOR, ALU_SLL, 4'd15, ALU_OR};
        logic [31:0] t_a   [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                                    32'd5, 32'h0F0F0000, 32'h0, 32'h12345678, 32'h100};
        logic [31:0] t_b   [10] = '{32'd1, 32'd1, 32'd1, 32'h80000000, 32'h80000000,
                                    32'd7, 32'h000000F0, 32'd1, 32'h9ABCDEF0, 32'hFFFF};
        logic [4:0]  t_sh  [10] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd0, 5'd31, 5'd0, 5'd0};
        logic [31:0] t_exp [10] = '{32'd1, 32'd0, 32'd0, 32'hF8000000, 32'h08000000,
                                    32'hFFFFFFFE, 32'hF0F0FF0F, 32'h80000000, 32'd0, 32'h10F};
        idle32();
        for (int i = 0; i < 10; i++) begin
            issue32(t_op[i], MD_NONE, t_a[i], t_b[i]);
            b32.ShamtD   = t_sh[i];
            b32.ALUSrcD  = (i == 9);
            b32.SignImmD = 32'h0F;
            tick();
            n_checks++;
            if (b32.ALUOutE !== t_exp[i]) begin
                n_fail++; $display("FAIL alu_vec%0d op%0d: got %08h expected %08h", i, t_op[i], b32.ALUOutE, t_exp[i]);
            end
        end
        idle32();
        tick();
    endtask

    task automatic test_mult();
        int          busy;
        logic [31:0] lo;
        logic [31:0] hi;
        md_run32(MD_MULT, 32'hFFFFFFFD, 32'd7, busy, lo, hi);
        n_checks++;
        if (busy != 33) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 33", busy); end
        n_checks++;
        if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo: got %08h expected FFFFFFEB", lo); end
        n_checks++;
        if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %08h expected FFFFFFFF", hi); end
    endtask

    task automatic test_div();
        logic [2:0]  d_op [4] = '{MD_DIVU, MD_DIV, MD_DIV, MD_DIV};
        logic [31:0] d_a  [4] = '{32'd100, 32'hFFFFFFF9, 32'd5, 32'h80000000};
        logic [31:0] d_b  [4] = '{32'd7, 32'd2, 32'd0, 32'hFFFFFFFF};
        logic [31:0] d_lo [4] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] d_hi [4] = '{32'd2, 32'hFFFFFFFF, 32'd5, 32'd0};
        int          busy;
        logic [31:0] lo;
        logic [31:0] hi;
        for (int i = 0; i < 4; i++) begin
            md_run32(d_op[i], d_a[i], d_b[i], busy, lo, hi);
            n_checks++;
            if (lo !== d_lo[i] || hi !== d_hi[i] || busy != 33) begin
                n_fail++;
                $display("FAIL div_vec%0d: got lo=%08h hi=%08h busy=%0d expected lo=%08h hi=%08h busy=33",
                         i, lo, hi, busy, d_lo[i], d_hi[i]);
            end
        end
    endtask

    task automatic test_stall();
        int   cyc;
        logic stable;
        idle32();
        issue32(ALU_AND, MD_MULT, 32'd3, 32'd4);
        tick();
        issue32(ALU_ADD, MD_NONE, 32'd10, 32'd20);
        tick();
        issue32(ALU_OR, MD_NONE, 32'hF0, 32'h0F);
        cyc    = 0;
        stable = 1'b1;
        while (b32.MDBusyE === 1'b1 && cyc < 100) begin
            if (b32.ALUOutE !== 32'd30) stable = 1'b0;
            cyc++;
            tick();
        end
        n_checks++;
        if (!stable || cyc != 33) begin
            n_fail++; $display("FAIL stall_busy_hold: got stable=%0b cycles=%0d expected 1/33", stable, cyc);
        end
        n_checks++;
        if (b32.ALUOutE !== 32'd30) begin n_fail++; $display("FAIL stall_held_at_idle: got %0d expected 30", b32.ALUOutE); end
        tick();
        n_checks++;
        if (b32.ALUOutE !== 32'hFF) begin n_fail++; $display("FAIL stall_advance: got %0h expected FF", b32.ALUOutE); end
        idle32();
        tick();
    endtask

    task automatic test_reset_mid();
        idle32();
        issue32(ALU_AND, MD_MULT, 32'd5, 32'd6);
        tick();
        issue32(ALU_AND, MD_NONE, 32'd0, 32'd0);
        tick();
        repeat (9) tick();
        n_checks++;
        if (b32.MDBusyE !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before_reset: got %0b expected 1", b32.MDBusyE); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (b32.MDBusyE !== 1'b0 || b32.ALUOutE !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset_immediate: got busy=%0b aluout=%0h expected 0/0", b32.MDBusyE, b32.ALUOutE);
        end
        rst_n = 1'b1;
        issue32(ALU_AND, MD_MFHI, 32'd0, 32'd0);
        tick();
        n_checks++;
        if (b32.ALUOutE !== 32'd0 || b32.MDBusyE !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_hi: got hi=%0h busy=%0b expected 0/0", b32.ALUOutE, b32.MDBusyE);
        end
        issue32(ALU_AND, MD_MFLO, 32'd0, 32'd0);
        tick();
        n_checks++;
        if (b32.ALUOutE !== 32'd0) begin n_fail++; $display("FAIL mid_reset_lo: got %0h expected 0", b32.ALUOutE); end
        idle32();
        tick();
    endtask

    task automatic test_dw16();
        int busy;
        idle16();
        b16.MDOpD = MD_MULTU; b16.RD1D = 16'hFFFF; b16.RD2D = 16'hFFFF;
        tick();
        b16.MDOpD = MD_MFLO; b16.RD1D = 16'h0; b16.RD2D = 16'h0;
        tick();
        busy = 0;
        while (b16.MDBusyE === 1'b1 && busy < 100) begin
            busy++;
            tick();
        end
        n_checks++;
        if (busy != 17) begin n_fail++; $display("FAIL dw16_busy_cycles: got %0d expected 17", busy); end
        n_checks++;
        if (b16.ALUOutE !== 16'h0001) begin n_fail++; $display("FAIL dw16_lo: got %04h expected 0001", b16.ALUOutE); end
        b16.MDOpD = MD_MFHI;
        tick();
        n_checks++;
        if (b16.ALUOutE !== 16'hFFFE) begin n_fail++; $display("FAIL dw16_hi: got %04h expected FFFE", b16.ALUOutE); end
        idle16();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forwarding();
        test_alu();
        test_mult();
        test_div();
        test_stall();
        test_reset_mid();
        test_dw16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
